// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared types and constants for the SRAM responder
package mem_pkg;

    localparam int WORD_W   = 16;
    localparam int MAX_WAIT = 15;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT    = 2'd1,
        RD_HOLD = 2'd2,
        WR_HOLD = 2'd3
    } mem_state_t;

endpackage

// File: rtl/sram_array.sv
// rtl/sram_array.sv - byte-lane writable word array with combinational read
//  clk    : write clock
//  we_hi  : write enable for wdata[15:8]
//  we_lo  : write enable for wdata[7:0]
//  idx    : word index for both read and write
//  wdata  : write data
//  rdata  : combinational read of mem[idx]
module sram_array
    import mem_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              we_hi,
    input  logic              we_lo,
    input  logic [ADDR_W-1:0] idx,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] rdata
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [WORD_W-1:0] mem [DEPTH];

    // Contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (we_hi) mem[idx][15:8] <= wdata[15:8];
        if (we_lo) mem[idx][7:0]  <= wdata[7:0];
    end

    assign rdata = mem[idx];

endmodule

// File: rtl/sram_responder.sv
// rtl/sram_responder.sv - SRAM-interface responder with programmable wait states
//  Clk, Reset      : clock, asynchronous active-low reset
//  ADDR            : word address, low ADDR_W bits index the array
//  CE/UB/LB/OE/WE  : active-low chip, byte-lane, read and write strobes
//  Data_in         : write data from the CPU bus
//  Data_out/Data_oe: read data and its bus-drive enable
//  Mem_Ready       : one-cycle completion pulse
//  Proto_err       : one-cycle pulse when OE and WE are both low at request
module sram_responder
    import mem_pkg::*;
#(
    parameter int ADDR_W      = 8,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [15:0] ADDR,
    input  logic        CE,
    input  logic        UB,
    input  logic        LB,
    input  logic        OE,
    input  logic        WE,
    input  logic [15:0] Data_in,
    output logic [15:0] Data_out,
    output logic        Data_oe,
    output logic        Mem_Ready,
    output logic        Proto_err
);

    localparam int               CNT_W    = $clog2(MAX_WAIT + 1);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WAIT_CYCLES);

    mem_state_t        state;
    logic [CNT_W-1:0]  cnt;
    logic [ADDR_W-1:0] addr_q;
    logic [WORD_W-1:0] data_q;
    logic              ub_q;
    logic              lb_q;
    logic              wr_q;

    logic              rd_req;
    logic              wr_req;
    logic              done;
    logic              arr_we_hi;
    logic              arr_we_lo;
    logic [WORD_W-1:0] arr_rdata;

    // A write wins over a read when OE and WE are both low.
    assign rd_req = ~CE & ~OE & WE;
    assign wr_req = ~CE & ~WE;

    // Last wait cycle of a non-aborted access.
    assign done      = (state == WAIT) & ~CE & (cnt == '0);
    assign arr_we_hi = done & wr_q & ~ub_q;
    assign arr_we_lo = done & wr_q & ~lb_q;

    // Combinational so the bus is released in the same cycle a strobe rises.
    assign Data_oe = (state == RD_HOLD) & ~CE & ~OE;

    generate
        if (ADDR_W < 16) begin : g_addr_alias
            logic addr_hi_unused;
            assign addr_hi_unused = ^ADDR[15:ADDR_W];
        end
    endgenerate

    sram_array #(
        .ADDR_W (ADDR_W)
    ) u_array (
        .clk   (Clk),
        .we_hi (arr_we_hi),
        .we_lo (arr_we_lo),
        .idx   (addr_q),
        .wdata (data_q),
        .rdata (arr_rdata)
    );

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state     <= IDLE;
            cnt       <= '0;
            addr_q    <= '0;
            data_q    <= '0;
            ub_q      <= 1'b1;
            lb_q      <= 1'b1;
            wr_q      <= 1'b0;
            Data_out  <= 16'h0000;
            Mem_Ready <= 1'b0;
            Proto_err <= 1'b0;
        end else begin
            Mem_Ready <= 1'b0;
            Proto_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (rd_req | wr_req) begin
                        state     <= WAIT;
                        cnt       <= CNT_INIT;
                        addr_q    <= ADDR[ADDR_W-1:0];
                        data_q    <= Data_in;
                        ub_q      <= UB;
                        lb_q      <= LB;
                        wr_q      <= wr_req;
                        Proto_err <= wr_req & ~OE;
                    end
                end
                WAIT: begin
                    if (CE) begin
                        state <= IDLE;
                    end else if (cnt != '0) begin
                        cnt <= cnt - CNT_W'(1);
                    end else begin
                        Mem_Ready <= 1'b1;
                        if (wr_q) begin
                            state <= WR_HOLD;
                        end else begin
                            Data_out <= {ub_q ? 8'h00 : arr_rdata[15:8],
                                         lb_q ? 8'h00 : arr_rdata[7:0]};
                            state    <= RD_HOLD;
                        end
                    end
                end
                // Hold until the strobe is released so one assertion is one access.
                RD_HOLD: if (CE | OE) state <= IDLE;
                WR_HOLD: if (CE | WE) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sram_responder.sv
// tb/tb_sram_responder.sv - directed self-checking bench for sram_responder
module tb_sram_responder;

    logic        Clk = 1'b0;
    logic        Reset;
    logic [15:0] ADDR;
    logic        CE, UB, LB, OE, WE;
    logic [15:0] Data_in;
    logic [15:0] Data_out;
    logic        Data_oe;
    logic        Mem_Ready;
    logic        Proto_err;

    int n_cmp = 0;
    int n_err = 0;

    localparam int LAT = 3;

    sram_responder #(
        .ADDR_W      (8),
        .WAIT_CYCLES (2)
    ) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .ADDR      (ADDR),
        .CE        (CE),
        .UB        (UB),
        .LB        (LB),
        .OE        (OE),
        .WE        (WE),
        .Data_in   (Data_in),
        .Data_out  (Data_out),
        .Data_oe   (Data_oe),
        .Mem_Ready (Mem_Ready),
        .Proto_err (Proto_err)
    );

    always #5 Clk = ~Clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_bus(input logic ce, input logic ub, input logic lb,
                           input logic oe, input logic we,
                           input logic [15:0] a, input logic [15:0] d);
        CE = ce; UB = ub; LB = lb; OE = oe; WE = we; ADDR = a; Data_in = d;
    endtask

    task automatic step();
        @(posedge Clk);
        @(negedge Clk);
    endtask

    task automatic idle_bus();
        CE = 1'b1; UB = 1'b1; LB = 1'b1; OE = 1'b1; WE = 1'b1;
        step();
    endtask

    // lat = number of edges after the sampling edge until Ready is seen.
    task automatic wait_ready(output int lat);
        lat = -1;
        for (int n = 0; n < 20; n++) begin
            step();
            if (Mem_Ready === 1'b1) begin
                lat = n;
                break;
            end
        end
    endtask

    task automatic do_write(input logic [15:0] a, input logic [15:0] d,
                            input logic ub, input logic lb, input string tag);
        int lat;
        set_bus(1'b0, ub, lb, 1'b1, 1'b0, a, d);
        wait_ready(lat);
        check({tag, "_lat"}, lat, LAT);
        idle_bus();
    endtask

    task automatic do_read(input logic [15:0] a, input logic ub, input logic lb,
                           input logic [15:0] exp, input string tag);
        int lat;
        set_bus(1'b0, ub, lb, 1'b0, 1'b1, a, 16'h0000);
        wait_ready(lat);
        check({tag, "_lat"}, lat, LAT);
        check({tag, "_data"}, Data_out, exp);
        check({tag, "_oe"}, Data_oe, 1'b1);
        idle_bus();
    endtask

    initial begin
        int lat;
        int rc;
        int oc;

        Reset = 1'b0;
        set_bus(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 16'h0000, 16'h0000);
        step();
        check("rst_data_out", Data_out, 16'h0000);
        check("rst_data_oe", Data_oe, 1'b0);
        check("rst_ready", Mem_Ready, 1'b0);
        check("rst_proto", Proto_err, 1'b0);
        Reset = 1'b1;
        step();

        // 1: full write then read, latency and bus release
        do_write(16'h0003, 16'h1234, 1'b0, 1'b0, "t1_wr");
        set_bus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0003, 16'h0000);
        wait_ready(lat);
        check("t1_rd_lat", lat, LAT);
        check("t1_rd_data", Data_out, 16'h1234);
        check("t1_rd_oe", Data_oe, 1'b1);
        step();
        check("t1_ready_pulse", Mem_Ready, 1'b0);
        check("t1_oe_held", Data_oe, 1'b1);
        CE = 1'b1;
        #1;
        check("t1_oe_release", Data_oe, 1'b0);
        idle_bus();

        // 2: byte-lane writes and lane-masked read
        do_write(16'h0005, 16'hABCD, 1'b0, 1'b0, "t2_wr_full");
        do_write(16'h0005, 16'h5500, 1'b0, 1'b1, "t2_wr_ub");
        do_read(16'h0005, 1'b0, 1'b0, 16'h55CD, "t2_rd_full");
        do_read(16'h0005, 1'b1, 1'b0, 16'h00CD, "t2_rd_lb");

        // 3: aborted read and aborted write
        set_bus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0005, 16'h0000);
        step();
        CE = 1'b1;
        rc = 0; oc = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (Mem_Ready === 1'b1) rc++;
            if (Data_oe === 1'b1) oc++;
        end
        check("t3_rd_abort_ready", rc, 0);
        check("t3_rd_abort_oe", oc, 0);
        idle_bus();
        set_bus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0005, 16'hDEAD);
        step();
        CE = 1'b1; WE = 1'b1;
        rc = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (Mem_Ready === 1'b1) rc++;
        end
        check("t3_wr_abort_ready", rc, 0);
        idle_bus();
        do_read(16'h0005, 1'b0, 1'b0, 16'h55CD, "t3_rd_after_abort");

        // 4: held write strobe gives one access; mid-access changes ignored
        set_bus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0009, 16'h0F0F);
        rc = 0;
        for (int i = 0; i < 14; i++) begin
            step();
            if (Mem_Ready === 1'b1) rc++;
            if (i == 1) begin
                ADDR    = 16'h000A;
                Data_in = 16'hAAAA;
            end
        end
        check("t4_hold_ready_count", rc, 1);
        idle_bus();
        do_read(16'h0009, 1'b0, 1'b0, 16'h0F0F, "t4_rd_once");
        do_write(16'h0009, 16'h1111, 1'b0, 1'b0, "t4_wr_again");
        do_read(16'h0009, 1'b0, 1'b0, 16'h1111, "t4_rd_again");

        // 5: OE and WE both low, then address aliasing
        set_bus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0020, 16'h7777);
        step();
        check("t5_proto_pulse", Proto_err, 1'b1);
        step();
        check("t5_proto_clear", Proto_err, 1'b0);
        wait_ready(lat);
        check("t5_proto_lat", lat, LAT - 2);
        check("t5_wr_hold_oe", Data_oe, 1'b0);
        idle_bus();
        do_read(16'h0020, 1'b0, 1'b0, 16'h7777, "t5_rd_proto");
        do_read(16'h0103, 1'b0, 1'b0, 16'h1234, "t5_rd_alias");
        do_write(16'h0203, 16'h4321, 1'b0, 1'b0, "t5_wr_alias");
        do_read(16'h0003, 1'b0, 1'b0, 16'h4321, "t5_rd_alias_wr");

        // 6: reset during read hold and during a write's wait states
        do_write(16'h0007, 16'h0707, 1'b0, 1'b0, "t6_wr_init");
        set_bus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0007, 16'h0000);
        wait_ready(lat);
        check("t6_rd_data", Data_out, 16'h0707);
        check("t6_rd_oe", Data_oe, 1'b1);
        Reset = 1'b0;
        #1;
        check("t6_rst_oe", Data_oe, 1'b0);
        check("t6_rst_data", Data_out, 16'h0000);
        check("t6_rst_ready", Mem_Ready, 1'b0);
        idle_bus();
        Reset = 1'b1;
        step();
        set_bus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0007, 16'hFFFF);
        step();
        step();
        Reset = 1'b0;
        #1;
        check("t6_wr_rst_ready", Mem_Ready, 1'b0);
        check("t6_wr_rst_oe", Data_oe, 1'b0);
        check("t6_wr_rst_proto", Proto_err, 1'b0);
        step();
        step();
        idle_bus();
        Reset = 1'b1;
        step();
        do_read(16'h0007, 1'b0, 1'b0, 16'h0707, "t6_rd_kept");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
